// File: rtl/dec_grant_sched_if.sv
// Request/grant bundle between the requesters and the decoder scheduler.
interface dec_grant_sched_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_en;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant_idx,
    input  grant_en,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant_idx,
    output grant_en,
    output busy,
    output timeout
  );
endinterface

// File: rtl/dec_grant_sched.sv
// Round-robin scheduler driving the select/enable pair of a 3-to-8 decoder,
// with a bounded hold time and a dead cycle between grants.
module dec_grant_sched #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dec_grant_sched_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state, state_nx;
  logic [2:0]       ptr, ptr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx_r, idx_nx;
  logic             en_r, en_nx;
  logic             busy_r, busy_nx;
  logic             to_r, to_nx;
  logic [2:0]       win_c;
  logic             found_c;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    win_c   = 3'd0;
    found_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found_c && bus.req[ptr + 3'(i)]) begin
        win_c   = ptr + 3'(i);
        found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 3'd0;
      cnt    <= '0;
      idx_r  <= 3'd0;
      en_r   <= 1'b0;
      busy_r <= 1'b0;
      to_r   <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      cnt    <= cnt_nx;
      idx_r  <= idx_nx;
      en_r   <= en_nx;
      busy_r <= busy_nx;
      to_r   <= to_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    idx_nx   = idx_r;
    en_nx    = en_r;
    busy_nx  = busy_r;
    to_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (found_c) begin
          idx_nx   = win_c;
          en_nx    = 1'b1;
          busy_nx  = 1'b1;
          cnt_nx   = CNT_W'(1);
          state_nx = GRANT;
        end
      end
      GRANT: begin
        // done and withdrawal outrank the hold limit, so they never flag timeout
        if (bus.done || !bus.req[idx_r] || (cnt == CNT_W'(HOLD_MAX))) begin
          state_nx = GAP;
          en_nx    = 1'b0;
          ptr_nx   = idx_r + 3'd1;
          to_nx    = !bus.done && bus.req[idx_r];
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        en_nx    = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  assign bus.grant_idx = idx_r;
  assign bus.grant_en  = en_r;
  assign bus.busy      = busy_r;
  assign bus.timeout   = to_r;

endmodule
